pll_lock_supervisor: RTL and testbench

//   Consumes the asynchronous LOCK output of a display PLL and produces a clean,

---
 rtl/pll_lock_supervisor.sv | 163 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronises LOCK, holds rst_pix until LOCK settles, filters dropouts.
// Optional WAIT_LOCK/SETTLE timeout flag enabled by defining PLL_LOCK_TIMEOUT_EN.
module pll_lock_supervisor #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned SETTLE_CYCLES  = 1024,
  parameter int unsigned GLITCH_CYCLES  = 4,
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic             pll_lock,
  input  logic             clear_stats,
  output logic             rst_pix,
  output logic             ready,
  output logic [CNT_W-1:0] loss_count,
  output logic             glitch_seen,
  output logic             timeout
);

  localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned LOW_W    = $clog2(GLITCH_CYCLES + 1);

  localparam logic [1:0] WAIT_LOCK = 2'd0;
  localparam logic [1:0] SETTLE    = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;

  if (SYNC_STAGES < 2 || SETTLE_CYCLES < 2 || GLITCH_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("pll_lock_supervisor: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [1:0]             state;
  logic [1:0]             state_next;
  logic [SETTLE_W-1:0]    settle_cnt;
  logic [SETTLE_W-1:0]    settle_cnt_next;
  logic [LOW_W-1:0]       low_cnt;
  logic [LOW_W-1:0]       low_cnt_next;
  logic                   loss_evt;
  logic                   glitch_evt;

  assign lock_s = sync_q[SYNC_STAGES-1];

  // LOCK synchroniser
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  // State and counter registers
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      state      <= WAIT_LOCK;
      settle_cnt <= '0;
      low_cnt    <= '0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_cnt_next;
      low_cnt    <= low_cnt_next;
    end
  end

  // Next-state: settle qualification and RUN dropout filtering
  always_comb begin
    state_next      = state;
    settle_cnt_next = settle_cnt;
    low_cnt_next    = low_cnt;
    loss_evt        = 1'b0;
    glitch_evt      = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_next      = SETTLE;
          settle_cnt_next = '0;
        end
      end
      SETTLE: begin
        if (!lock_s) begin
          state_next = WAIT_LOCK;
        end else if (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
          state_next   = RUN;
          low_cnt_next = '0;
        end else begin
          settle_cnt_next = settle_cnt + SETTLE_W'(1);
        end
      end
      RUN: begin
        if (low_cnt == LOW_W'(GLITCH_CYCLES)) begin
          state_next   = WAIT_LOCK;
          low_cnt_next = '0;
          loss_evt     = 1'b1;
        end else if (lock_s) begin
          glitch_evt   = (low_cnt != '0);
          low_cnt_next = '0;
        end else begin
          low_cnt_next = low_cnt + LOW_W'(1);
        end
      end
      default: begin
        state_next = WAIT_LOCK;
      end
    endcase
  end

  // Registered outputs; clear_stats wins over same-cycle events
  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      rst_pix     <= 1'b1;
      ready       <= 1'b0;
      loss_count  <= '0;
      glitch_seen <= 1'b0;
    end else begin
      rst_pix <= (state != RUN);
      ready   <= (state == RUN);
      if (clear_stats) begin
        loss_count  <= '0;
        glitch_seen <= 1'b0;
      end else begin
        if (loss_evt && (loss_count != '1)) begin
          loss_count <= loss_count + CNT_W'(1);
        end
        if (glitch_evt) begin
          glitch_seen <= 1'b1;
        end
      end
    end
  end

`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] timeout_cnt;
  logic            timeout_hit;

  // Counter stops one short of the limit so it never needs an extra bit
  assign timeout_hit = (state != RUN) && (timeout_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      timeout_cnt <= '0;
      timeout     <= 1'b0;
    end else begin
      if (state == RUN) begin
        timeout_cnt <= '0;
      end else if (!timeout_hit) begin
        timeout_cnt <= timeout_cnt + TO_W'(1);
      end
      if (clear_stats) begin
        timeout <= 1'b0;
      end else if (timeout_hit) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed scenarios plus randomized LOCK
// traffic compared every cycle against a run-length reference model.
module tb_pll_lock_supervisor;

  localparam int SYNC_STAGES    = 2;
  localparam int SETTLE_CYCLES  = 16;
  localparam int GLITCH_CYCLES  = 4;
  localparam int CNT_W          = 8;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int RELEASE_EDGES  = SYNC_STAGES + SETTLE_CYCLES + 1;
  localparam int LOSS_EDGES     = SYNC_STAGES + GLITCH_CYCLES + 1;
  localparam int MAX_LOSS       = (1 << CNT_W) - 1;

  logic             clk_pix = 1'b0;
  logic             rst_n = 1'b0;
  logic             pll_lock = 1'b0;
  logic             clear_stats = 1'b0;
  logic             rst_pix;
  logic             ready;
  logic [CNT_W-1:0] loss_count;
  logic             glitch_seen;
  logic             timeout;

  int passed = 0;
  int total  = 0;

  pll_lock_supervisor #(
    .SYNC_STAGES   (SYNC_STAGES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .GLITCH_CYCLES (GLITCH_CYCLES),
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_pix    (clk_pix),
    .rst_n      (rst_n),
    .pll_lock   (pll_lock),
    .clear_stats(clear_stats),
    .rst_pix    (rst_pix),
    .ready      (ready),
    .loss_count (loss_count),
    .glitch_seen(glitch_seen),
    .timeout    (timeout)
  );

  always #5 clk_pix = ~clk_pix;

  // Reference model: run lengths of synced LOCK decide lock-up and loss
  bit m_pipe [SYNC_STAGES];
  bit m_running, m_was, m_ls, m_lev, m_gev, m_tev;
  bit m_glitch, m_to, m_rst_pix = 1'b1, m_ready;
  int m_high, m_low, m_loss, m_nr;

  always @(posedge clk_pix) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) m_pipe[i] = 1'b0;
      m_running = 0; m_high = 0; m_low = 0; m_loss = 0; m_nr = 0;
      m_glitch = 0; m_to = 0; m_rst_pix = 1; m_ready = 0;
    end else begin
      m_ls = m_pipe[SYNC_STAGES-1];
      m_was = m_running;
      m_lev = 0; m_gev = 0; m_tev = 0;
      if (!m_was) begin
        m_high = m_ls ? m_high + 1 : 0;
        if (m_high == SETTLE_CYCLES + 1) begin
          m_running = 1; m_high = 0; m_low = 0;
        end
        if (m_nr < TIMEOUT_CYCLES) m_nr = m_nr + 1;
`ifdef PLL_LOCK_TIMEOUT_EN
        m_tev = (m_nr >= TIMEOUT_CYCLES);
`endif
      end else begin
        m_nr = 0;
        if (m_low == GLITCH_CYCLES) begin
          m_running = 0; m_low = 0; m_lev = 1;
        end else if (m_ls) begin
          m_gev = (m_low > 0); m_low = 0;
        end else begin
          m_low = m_low + 1;
        end
      end
      if (clear_stats) begin
        m_loss = 0; m_glitch = 0; m_to = 0;
      end else begin
        if (m_lev && m_loss < MAX_LOSS) m_loss = m_loss + 1;
        if (m_gev) m_glitch = 1;
        if (m_tev) m_to = 1;
      end
      m_rst_pix = !m_was;
      m_ready = m_was;
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = pll_lock;
    end
  end

  function automatic logic [CNT_W+3:0] dut_vec();
    return {rst_pix, ready, loss_count, glitch_seen, timeout};
  endfunction

  function automatic logic [CNT_W+3:0] mdl_vec();
    return {m_rst_pix, m_ready, CNT_W'(m_loss), m_glitch, m_to};
  endfunction

  task automatic test_reset();
    rst_n = 0; pll_lock = 1; clear_stats = 0;
    repeat (3) @(negedge clk_pix);
    total++; if (rst_pix !== 1'b1) $display("FAIL reset_rst_pix got %b exp 1", rst_pix); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL reset_ready got %b exp 0", ready); else passed++;
    total++; if (loss_count !== '0) $display("FAIL reset_loss got %0d exp 0", loss_count); else passed++;
    total++; if (glitch_seen !== 1'b0) $display("FAIL reset_glitch got %b exp 0", glitch_seen); else passed++;
    total++; if (timeout !== 1'b0) $display("FAIL reset_timeout got %b exp 0", timeout); else passed++;
    pll_lock = 0;
  endtask

  task automatic test_lockup();
    int n; bit got;
    rst_n = 0; pll_lock = 0;
    repeat (3) @(negedge clk_pix);
    rst_n = 1;
    repeat (7) begin
      @(negedge clk_pix);
      total++; if (dut_vec() !== mdl_vec()) $display("FAIL lockup_pre got %h exp %h", dut_vec(), mdl_vec()); else passed++;
    end
    pll_lock = 1; n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk_pix); n++;
      total++; if (dut_vec() !== mdl_vec()) $display("FAIL lockup_model got %h exp %h", dut_vec(), mdl_vec()); else passed++;
      if (rst_pix === 1'b0) got = 1;
    end
    total++; if (!got || n - 1 != RELEASE_EDGES) $display("FAIL lockup_edges got %0d exp %0d", n - 1, RELEASE_EDGES); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL lockup_ready got %b exp 1", ready); else passed++;
  endtask

  task automatic test_short_dropout();
    repeat (4) @(negedge clk_pix);
    pll_lock = 0;
    repeat (GLITCH_CYCLES - 1) begin
      @(negedge clk_pix);
      total++; if (rst_pix !== 1'b0) $display("FAIL short_rst_pix got %b exp 0", rst_pix); else passed++;
    end
    pll_lock = 1;
    repeat (6) begin
      @(negedge clk_pix);
      total++; if (dut_vec() !== mdl_vec()) $display("FAIL short_model got %h exp %h", dut_vec(), mdl_vec()); else passed++;
      total++; if (rst_pix !== 1'b0) $display("FAIL short_rst_pix got %b exp 0", rst_pix); else passed++;
    end
    total++; if (glitch_seen !== 1'b1) $display("FAIL short_glitch got %b exp 1", glitch_seen); else passed++;
    total++; if (loss_count !== '0) $display("FAIL short_loss got %0d exp 0", loss_count); else passed++;
  endtask

  task automatic test_real_loss();
    int n; bit got;
    pll_lock = 0; n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge clk_pix); n++;
      total++; if (dut_vec() !== mdl_vec()) $display("FAIL loss_model got %h exp %h", dut_vec(), mdl_vec()); else passed++;
      if (rst_pix === 1'b1) got = 1;
    end
    total++; if (!got || n - 1 != LOSS_EDGES) $display("FAIL loss_edges got %0d exp %0d", n - 1, LOSS_EDGES); else passed++;
    repeat ($urandom_range(4, 0)) @(negedge clk_pix);
    total++; if (loss_count !== CNT_W'(1)) $display("FAIL loss_count got %0d exp 1", loss_count); else passed++;
    pll_lock = 1; n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk_pix); n++;
      total++; if (dut_vec() !== mdl_vec()) $display("FAIL relock_model got %h exp %h", dut_vec(), mdl_vec()); else passed++;
      if (rst_pix === 1'b0) got = 1;
    end
    total++; if (!got || n - 1 != RELEASE_EDGES) $display("FAIL relock_edges got %0d exp %0d", n - 1, RELEASE_EDGES); else passed++;
  endtask

  task automatic test_settle_dropout();
    int n; bit got;
    rst_n = 0; pll_lock = 0;
    @(negedge clk_pix);
    total++; if (rst_pix !== 1'b1 || ready !== 1'b0) $display("FAIL run_reset got %b%b exp 10", rst_pix, ready); else passed++;
    rst_n = 1;
    repeat (4) @(negedge clk_pix);
    // Edges 0..10 sample high, edge 11 low: lock_s drops when settle_cnt is 10
    pll_lock = 1;
    repeat (11) @(negedge clk_pix);
    pll_lock = 0;
    @(negedge clk_pix);
    pll_lock = 1; n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk_pix); n++;
      total++; if (dut_vec() !== mdl_vec()) $display("FAIL settle_model got %h exp %h", dut_vec(), mdl_vec()); else passed++;
      if (rst_pix === 1'b0) got = 1;
    end
    total++; if (!got || 11 + n != 12 + RELEASE_EDGES) $display("FAIL settle_edges got %0d exp %0d", 11 + n, 12 + RELEASE_EDGES); else passed++;
  endtask

  task automatic test_mid_reset();
    int n;
    rst_n = 0; pll_lock = 1;
    @(negedge clk_pix);
    rst_n = 1;
    repeat (SYNC_STAGES + 6) @(negedge clk_pix);
    rst_n = 0;
    @(negedge clk_pix);
    total++; if (dut_vec() !== {2'b10, CNT_W'(0), 2'b00}) $display("FAIL settle_reset got %h exp %h", dut_vec(), {2'b10, CNT_W'(0), 2'b00}); else passed++;
    rst_n = 1;
    n = 0; while (ready !== 1'b1 && n < 40) begin @(negedge clk_pix); n++; end
    pll_lock = 0; repeat (2) @(negedge clk_pix);
    pll_lock = 1; repeat (3) @(negedge clk_pix);
    pll_lock = 0; repeat (LOSS_EDGES + 1) @(negedge clk_pix);
    pll_lock = 1;
    n = 0; while (ready !== 1'b1 && n < 40) begin @(negedge clk_pix); n++; end
    total++; if (dut_vec() !== mdl_vec()) $display("FAIL prerun_model got %h exp %h", dut_vec(), mdl_vec()); else passed++;
    total++; if (glitch_seen !== 1'b1 || loss_count !== CNT_W'(1)) $display("FAIL prerun_stats got %b/%0d exp 1/1", glitch_seen, loss_count); else passed++;
    rst_n = 0;
    @(negedge clk_pix);
    total++; if (dut_vec() !== {2'b10, CNT_W'(0), 2'b00}) $display("FAIL midrun_reset got %h exp %h", dut_vec(), {2'b10, CNT_W'(0), 2'b00}); else passed++;
    rst_n = 1;
  endtask

  task automatic test_saturation();
    int n;
    rst_n = 0; pll_lock = 0; clear_stats = 0;
    @(negedge clk_pix);
    rst_n = 1;
    for (int k = 0; k < 300; k++) begin
      pll_lock = 1; n = 0;
      while (ready !== 1'b1 && n < 40) begin
        @(negedge clk_pix); n++;
        total++; if (dut_vec() !== mdl_vec()) $display("FAIL sat_model got %h exp %h", dut_vec(), mdl_vec()); else passed++;
      end
      pll_lock = 0;
      repeat (LOSS_EDGES + 1) begin
        @(negedge clk_pix);
        total++; if (dut_vec() !== mdl_vec()) $display("FAIL sat_model got %h exp %h", dut_vec(), mdl_vec()); else passed++;
      end
    end
    total++; if (loss_count !== CNT_W'(MAX_LOSS)) $display("FAIL sat_loss got %0d exp %0d", loss_count, MAX_LOSS); else passed++;
    pll_lock = 1; n = 0;
    while (ready !== 1'b1 && n < 40) begin @(negedge clk_pix); n++; end
    pll_lock = 0; repeat (2) @(negedge clk_pix);
    pll_lock = 1; repeat (4) @(negedge clk_pix);
    total++; if (glitch_seen !== 1'b1) $display("FAIL sat_glitch got %b exp 1", glitch_seen); else passed++;
    clear_stats = 1; pll_lock = 0;
    repeat (LOSS_EDGES + 1) @(negedge clk_pix);
    clear_stats = 0;
    total++; if (rst_pix !== 1'b1) $display("FAIL clr_rst_pix got %b exp 1", rst_pix); else passed++;
    total++; if (loss_count !== '0) $display("FAIL clr_loss got %0d exp 0", loss_count); else passed++;
    total++; if (glitch_seen !== 1'b0) $display("FAIL clr_glitch got %b exp 0", glitch_seen); else passed++;
    total++; if (dut_vec() !== mdl_vec()) $display("FAIL clr_model got %h exp %h", dut_vec(), mdl_vec()); else passed++;
  endtask

  task automatic test_random();
    int n;
    for (int ev = 0; ev < 60; ev++) begin
      pll_lock = 1; n = $urandom_range(30, 12);
      for (int c = 0; c < n; c++) begin
        clear_stats = ($urandom_range(15, 0) == 0);
        rst_n = ($urandom_range(80, 0) != 0);
        @(negedge clk_pix);
        total++; if (dut_vec() !== mdl_vec()) $display("FAIL rand_model ev %0d got %h exp %h", ev, dut_vec(), mdl_vec()); else passed++;
      end
      pll_lock = 0; n = $urandom_range(7, 1);
      for (int c = 0; c < n; c++) begin
        clear_stats = ($urandom_range(15, 0) == 0);
        rst_n = 1;
        @(negedge clk_pix);
        total++; if (dut_vec() !== mdl_vec()) $display("FAIL rand_model ev %0d got %h exp %h", ev, dut_vec(), mdl_vec()); else passed++;
      end
    end
    clear_stats = 0; rst_n = 1;
  endtask

  task automatic test_timeout();
    int n;
    rst_n = 0; pll_lock = 0; clear_stats = 0;
    @(negedge clk_pix);
    rst_n = 1;
`ifdef PLL_LOCK_TIMEOUT_EN
    repeat (TIMEOUT_CYCLES - 1) @(negedge clk_pix);
    total++; if (timeout !== 1'b0) $display("FAIL to_early got %b exp 0", timeout); else passed++;
    @(negedge clk_pix);
    total++; if (timeout !== 1'b1) $display("FAIL to_set got %b exp 1", timeout); else passed++;
    pll_lock = 1; n = 0;
    while (ready !== 1'b1 && n < 40) begin @(negedge clk_pix); n++; end
    total++; if (ready !== 1'b1 || timeout !== 1'b1) $display("FAIL to_run got %b%b exp 11", ready, timeout); else passed++;
    clear_stats = 1; @(negedge clk_pix); clear_stats = 0;
    @(negedge clk_pix);
    total++; if (timeout !== 1'b0) $display("FAIL to_clear got %b exp 0", timeout); else passed++;
`else
    repeat (TIMEOUT_CYCLES + 50) begin
      @(negedge clk_pix);
      total++; if (timeout !== 1'b0) $display("FAIL to_off got %b exp 0", timeout); else passed++;
    end
    pll_lock = 1; n = 0;
    while (ready !== 1'b1 && n < 40) begin @(negedge clk_pix); n++; end
    total++; if (ready !== 1'b1 || timeout !== 1'b0) $display("FAIL to_off_run got %b%b exp 10", ready, timeout); else passed++;
`endif
    total++; if (dut_vec() !== mdl_vec()) $display("FAIL to_model got %h exp %h", dut_vec(), mdl_vec()); else passed++;
  endtask

  initial begin
    @(negedge clk_pix);
    test_reset();
    test_lockup();
    test_short_dropout();
    test_real_loss();
    test_settle_dropout();
    test_mid_reset();
    test_saturation();
    test_random();
    test_timeout();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired after %0d/%0d checks", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
